// File: rtl/present_pkg.sv
// Shared constants, FSM encoding and PRESENT-80 helper functions for the decrypt core.
// Optional key cache in the core is enabled by defining PRESENT_KEYCACHE_EN.
package present_pkg;

  localparam int BLK_W      = 64;
  localparam int KEY_W      = 80;
  localparam int NUM_ROUNDS = 31;
  localparam int RC_W       = 5;

  // Nibble i of each table holds S(i) / Sinv(i).
  localparam logic [63:0] SBOX_TAB     = 64'h21748FE3DA09B65C;
  localparam logic [63:0] SBOX_INV_TAB = 64'hA970364BD21C8FE5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_KEXP = 2'd1,
    ST_DEC  = 2'd2,
    ST_DONE = 2'd3
  } fsm_state_t;

  function automatic logic [3:0] s_nib(input logic [3:0] x);
    return SBOX_TAB[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] sinv_nib(input logic [3:0] x);
    return SBOX_INV_TAB[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [BLK_W-1:0] sinv_layer(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] r;
    r = '0;
    for (int n = 0; n < 16; n++) r[4*n +: 4] = sinv_nib(s[4*n +: 4]);
    return r;
  endfunction

  function automatic logic [BLK_W-1:0] p_inv_layer(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] r;
    r = '0;
    for (int j = 0; j < 63; j++) r[(4*j) % 63] = s[j];
    r[63] = s[63];
    return r;
  endfunction

  // One forward key-schedule step: K_rc -> K_rc+1.
  function automatic logic [KEY_W-1:0] key_sched_fwd(input logic [KEY_W-1:0] k,
                                                     input logic [RC_W-1:0]  rc);
    logic [KEY_W-1:0] r;
    r          = {k[18:0], k[79:19]};
    r[79:76]   = s_nib(r[79:76]);
    r[19:15]   = r[19:15] ^ rc;
    return r;
  endfunction

  // Undo one forward step: K_rc+1 -> K_rc.
  function automatic logic [KEY_W-1:0] key_sched_inv(input logic [KEY_W-1:0] k,
                                                     input logic [RC_W-1:0]  rc);
    logic [KEY_W-1:0] r;
    r        = k;
    r[19:15] = r[19:15] ^ rc;
    r[79:76] = sinv_nib(r[79:76]);
    return {r[60:0], r[79:61]};
  endfunction

endpackage

// File: rtl/present_dec_core_if.sv
// Input (ct/key) and output (pt) streams of the PRESENT decrypt core.
// Both streams: a transfer happens on a rising edge where valid & ready are both high;
// the producer holds payload stable while valid is high and ready has not been seen.
interface present_dec_core_if;
  import present_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [BLK_W-1:0] ct;
  logic [KEY_W-1:0] key;
  logic             out_valid;
  logic             out_ready;
  logic [BLK_W-1:0] pt;

  modport master (
    output in_valid, ct, key, out_ready,
    input  in_ready, out_valid, pt
  );

  modport slave (
    input  in_valid, ct, key, out_ready,
    output in_ready, out_valid, pt
  );
endinterface

// File: rtl/present_inv_round.sv
// Combinational PRESENT inverse round: derives K_rc from K_rc+1 and applies
// inverse pLayer, inverse S-box layer and round-key add.
module present_inv_round
  import present_pkg::*;
(
  input  logic [BLK_W-1:0] state,
  input  logic [KEY_W-1:0] key_in,
  input  logic [RC_W-1:0]  rc,
  output logic [BLK_W-1:0] state_out,
  output logic [KEY_W-1:0] key_out
);

  logic [KEY_W-1:0] k_rc;

  always_comb begin
    k_rc      = key_sched_inv(key_in, rc);
    key_out   = k_rc;
    state_out = sinv_layer(p_inv_layer(state)) ^ k_rc[79:16];
  end

endmodule

// File: rtl/present_dec_core.sv
// Iterative PRESENT-80 decryption: forward key expansion to K32, then 31 inverse rounds.
// Define PRESENT_KEYCACHE_EN to cache the last master key / K32 and skip expansion on a hit.
module present_dec_core
  import present_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  present_dec_core_if.slave bus,
  output fsm_state_t        dbg_state
);

  localparam logic [RC_W-1:0] RC_LAST = RC_W'(NUM_ROUNDS);

  fsm_state_t       fsm_q, fsm_d;
  logic [BLK_W-1:0] st_q, st_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [RC_W-1:0]  rc_q, rc_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [BLK_W-1:0] rnd_state;
  logic [KEY_W-1:0] rnd_key;
  logic [KEY_W-1:0] fwd_key;

`ifdef PRESENT_KEYCACHE_EN
  logic             cache_valid_q, cache_valid_d;
  logic [KEY_W-1:0] cache_mkey_q, cache_mkey_d;
  logic [KEY_W-1:0] cache_k32_q, cache_k32_d;
  logic [KEY_W-1:0] mkey_q, mkey_d;
  logic             hit_q, hit_d;
`endif

  present_inv_round u_round (
    .state     (st_q),
    .key_in    (key_q),
    .rc        (rc_q),
    .state_out (rnd_state),
    .key_out   (rnd_key)
  );

  assign fwd_key = key_sched_fwd(key_q, rc_q);

  always_comb begin
    fsm_d = fsm_q;
    st_d  = st_q;
    key_d = key_q;
    rc_d  = rc_q;
`ifdef PRESENT_KEYCACHE_EN
    cache_valid_d = cache_valid_q;
    cache_mkey_d  = cache_mkey_q;
    cache_k32_d   = cache_k32_q;
    mkey_d        = mkey_q;
    hit_d         = hit_q;
`endif
    case (fsm_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          st_d  = bus.ct;
          key_d = bus.key;
          rc_d  = 5'd1;
          fsm_d = ST_KEXP;
`ifdef PRESENT_KEYCACHE_EN
          mkey_d = bus.key;
          hit_d  = cache_valid_q && (bus.key == cache_mkey_q);
          if (hit_d) key_d = cache_k32_q;
`endif
        end
      end
      ST_KEXP: begin
`ifdef PRESENT_KEYCACHE_EN
        if (hit_q) begin
          // Key register already holds K32: only the whitening step remains.
          st_d  = st_q ^ key_q[79:16];
          rc_d  = RC_LAST;
          fsm_d = ST_DEC;
          hit_d = 1'b0;
        end else begin
`endif
          key_d = fwd_key;
          rc_d  = rc_q + 5'd1;
          if (rc_q == RC_LAST) begin
            st_d  = st_q ^ fwd_key[79:16];
            rc_d  = RC_LAST;
            fsm_d = ST_DEC;
`ifdef PRESENT_KEYCACHE_EN
            cache_valid_d = 1'b1;
            cache_mkey_d  = mkey_q;
            cache_k32_d   = fwd_key;
`endif
          end
`ifdef PRESENT_KEYCACHE_EN
        end
`endif
      end
      ST_DEC: begin
        st_d  = rnd_state;
        key_d = rnd_key;
        rc_d  = rc_q - 5'd1;
        if (rc_q == 5'd1) fsm_d = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) fsm_d = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
    in_ready_d  = (fsm_d == ST_IDLE);
    out_valid_d = (fsm_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= ST_IDLE;
      st_q        <= '0;
      key_q       <= '0;
      rc_q        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      st_q        <= st_d;
      key_q       <= key_d;
      rc_q        <= rc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef PRESENT_KEYCACHE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_valid_q <= 1'b0;
      cache_mkey_q  <= '0;
      cache_k32_q   <= '0;
      mkey_q        <= '0;
      hit_q         <= 1'b0;
    end else begin
      cache_valid_q <= cache_valid_d;
      cache_mkey_q  <= cache_mkey_d;
      cache_k32_q   <= cache_k32_d;
      mkey_q        <= mkey_d;
      hit_q         <= hit_d;
    end
  end
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.pt        = st_q;
  assign dbg_state     = fsm_q;

endmodule

// File: tb/tb_present_dec_core.sv
// Bench for present_dec_core: known vectors, latency, output stall, mid-run reset and a
// randomized stream checked against a PRESENT-80 encryption model.
module tb_present_dec_core;
  import present_pkg::*;

`ifdef PRESENT_KEYCACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  logic       clk;
  logic       rst;
  fsm_state_t dbg_state;

  present_dec_core_if bus();

  present_dec_core dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] exp_q[$];

  // Cache behaviour model: remembers the last accepted master key.
  bit          mdl_cache_valid = 1'b0;
  logic [79:0] mdl_cache_key   = '0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_encrypt(input logic [63:0] p, input logic [79:0] k);
    logic [3:0]  sb [16];
    logic [63:0] s, t;
    logic [79:0] kr, kt;
    sb = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
           4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
    s  = p;
    kr = k;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ kr[79:16];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = sb[s[4*n +: 4]];
      t = '0;
      for (int i = 0; i < 64; i++) t[(i == 63) ? 63 : ((16 * i) % 63)] = s[i];
      s  = t;
      kt = '0;
      for (int i = 0; i < 80; i++) kt[(i + 61) % 80] = kr[i];
      kr         = kt;
      kr[79:76]  = sb[kr[79:76]];
      kr[19:15]  = kr[19:15] ^ 5'(r);
    end
    return s ^ kr[79:16];
  endfunction

  function automatic int model_latency(input logic [79:0] k);
    int lat;
    lat = (CACHE_ON && mdl_cache_valid && (k == mdl_cache_key)) ? 32 : 62;
    mdl_cache_valid = 1'b1;
    mdl_cache_key   = k;
    return lat;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_input(input logic [63:0] c, input logic [79:0] k, output int exp_lat);
    int n;
    n            = 0;
    exp_lat      = 0;
    bus.in_valid = 1'b1;
    bus.ct       = c;
    bus.key      = k;
    while (bus.in_ready !== 1'b1 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) begin
      n_checks++; n_fail++;
      $display("FAIL in_ready_timeout: in_ready=%b after %0d cycles, required 1", bus.in_ready, n);
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      exp_lat = model_latency(k);
    end
  endtask

  task automatic wait_output(input int exp_lat, input logic [63:0] exp_pt, input string name);
    int lat;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (lat != exp_lat) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d cycles, required %0d", name, lat, exp_lat);
    end
    n_checks++;
    if (bus.pt !== exp_pt) begin
      n_fail++;
      $display("FAIL %s_pt: got %h, required %h", name, bus.pt, exp_pt);
    end
  endtask

  task automatic ack_output(input string name);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_after_ack: in_ready=%b out_valid=%b, required 1/0",
               name, bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic run_block(input logic [63:0] c, input logic [79:0] k,
                           input logic [63:0] exp_pt, input string name);
    int lat;
    drive_input(c, k, lat);
    if (lat != 0) begin
      wait_output(lat, exp_pt, name);
      ack_output(name);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.ct        = '0;
    bus.key       = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready);
    end
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b, required 0", bus.out_valid);
    end
    n_checks++;
    if (bus.pt !== 64'h0) begin
      n_fail++; $display("FAIL reset_pt: got %h, required 0", bus.pt);
    end
    n_checks++;
    if (dbg_state !== ST_IDLE) begin
      n_fail++; $display("FAIL reset_state: got %0d, required %0d", dbg_state, ST_IDLE);
    end
  endtask

  task automatic test_known_vectors();
    run_block(64'h5579C1387B228445, 80'h0, 64'h0, "kv_zero_key");
    run_block(64'hE72C46C0F5945049, {80{1'b1}}, 64'h0, "kv_ones_key_a");
    run_block(64'h3333DCD3213210D2, {80{1'b1}}, {64{1'b1}}, "kv_ones_key_b");
    run_block(64'hA112FFC72F68417B, 80'h0, {64{1'b1}}, "kv_zero_key_ones");
  endtask

  task automatic test_output_stall();
    logic [63:0] pa, pb;
    logic [79:0] ka, kb;
    logic [95:0] r;
    int          lat;
    pa = {$urandom(), $urandom()};
    pb = {$urandom(), $urandom()};
    r  = {$urandom(), $urandom(), $urandom()}; ka = r[79:0];
    r  = {$urandom(), $urandom(), $urandom()}; kb = r[79:0];
    drive_input(ref_encrypt(pa, ka), ka, lat);
    wait_output(lat, pa, "stall_a");
    // Offer a second block while the first output is held.
    bus.in_valid = 1'b1;
    bus.ct       = ref_encrypt(pb, kb);
    bus.key      = kb;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (bus.pt !== pa || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold cycle %0d: pt=%h in_ready=%b out_valid=%b, required pt=%h in_ready=0 out_valid=1",
                 i, bus.pt, bus.in_ready, bus.out_valid, pa);
      end
    end
    ack_output("stall_a");
    run_block(ref_encrypt(pb, kb), kb, pb, "stall_b");
  endtask

  task automatic test_mid_reset();
    logic [63:0] p;
    logic [79:0] k;
    logic [95:0] r;
    int          lat, n;
    p = {$urandom(), $urandom()};
    r = {$urandom(), $urandom(), $urandom()}; k = r[79:0];
    drive_input(ref_encrypt(p, k), k, lat);
    n = 0;
    while (dbg_state !== ST_DEC && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (dbg_state !== ST_DEC) begin
      n_fail++; $display("FAIL midrst_reach_dec: state=%0d, required %0d", dbg_state, ST_DEC);
    end
    repeat (16) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL midrst_abort: out_valid=%b in_ready=%b state=%0d, required 0/1/%0d",
               bus.out_valid, bus.in_ready, dbg_state, ST_IDLE);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    mdl_cache_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL midrst_in_ready: got %b, required 1", bus.in_ready);
    end
    run_block(ref_encrypt(p, k), k, p, "midrst_next");
  endtask

  task automatic test_random_stream();
    fork
      begin : driver
        logic [63:0] p;
        logic [79:0] k;
        logic [95:0] r;
        bit          acc;
        int          n;
        k = '0;
        for (int i = 0; i < 200; i++) begin
          bus.in_valid = 1'b0;
          repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
          end
          p = {$urandom(), $urandom()};
          if (i == 0 || $urandom_range(0, 3) != 0) begin
            r = {$urandom(), $urandom(), $urandom()};
            k = r[79:0];
          end
          bus.ct       = ref_encrypt(p, k);
          bus.key      = k;
          bus.in_valid = 1'b1;
          n   = 0;
          acc = 1'b0;
          while (!acc && n < 500) begin
            acc = (bus.in_ready === 1'b1);
            @(posedge clk); #1;
            n++;
          end
          bus.in_valid = 1'b0;
          if (!acc) begin
            n_checks++; n_fail++;
            $display("FAIL rand_accept_timeout: block %0d not accepted", i);
            break;
          end
          exp_q.push_back(p);
        end
        bus.in_valid = 1'b0;
      end
      begin : monitor
        logic [63:0] e;
        int          got, cyc;
        got = 0;
        cyc = 0;
        while (got < 200 && cyc < 60000) begin
          bus.out_ready = ($urandom_range(0, 3) != 0);
          if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
              n_fail++;
              $display("FAIL rand_unexpected_output: pt=%h with empty expected queue", bus.pt);
            end else begin
              e = exp_q.pop_front();
              if (bus.pt !== e) begin
                n_fail++;
                $display("FAIL rand_pt block %0d: got %h, required %h", got, bus.pt, e);
              end
            end
            got++;
          end
          @(posedge clk); #1;
          cyc++;
        end
        bus.out_ready = 1'b0;
        if (got < 200) begin
          n_checks++; n_fail++;
          $display("FAIL rand_output_timeout: got %0d blocks, required 200", got);
        end
      end
    join
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_known_vectors();
    test_output_stall();
    test_mid_reset();
    test_random_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
